// File: rtl/sram_like_slave_if.sv
// SRAM-like request/response bus between a master and sram_like_slave.
interface sram_like_slave_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_slave.sv
// SRAM-like slave: word memory with an in-order response queue of QDEPTH entries.
// Define SRAM_SLAVE_RAND_DELAY_EN to add LFSR-driven stalls on acceptance and response.
module sram_like_slave #(
   parameter int unsigned MEM_AW = 10,
   parameter int unsigned QDEPTH = 2
) (
   input logic              clk,
   input logic              resetn,
   sram_like_slave_if.slave bus
);
   localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned OccW = $clog2(QDEPTH + 1);

   logic [31:0]       mem_q [2**MEM_AW];
   logic [QDEPTH-1:0] q_is_read_q;
   logic [31:0]       q_data_q [QDEPTH];
   logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [OccW-1:0]   occ_q, occ_d;
   logic [MEM_AW-1:0] idx;
   logic              acc_ok, ret_ok, full, accept, retire;
   logic              unused_bits;

   assign idx         = bus.addr[MEM_AW+1:2];
   assign unused_bits = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

`ifdef SRAM_SLAVE_RAND_DELAY_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci taps 16,14,13,11 shifted towards the MSB.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (!resetn) lfsr_q <= 16'hACE1;
      else         lfsr_q <= lfsr_d;
   end

   assign acc_ok = lfsr_q[0];
   assign ret_ok = lfsr_q[1];
`else
   assign acc_ok = 1'b1;
   assign ret_ok = 1'b1;
`endif

   // Slot freed by a same-cycle retirement is not reused until the next cycle.
   assign full   = (occ_q == OccW'(QDEPTH));
   assign accept = resetn & bus.req & ~full & acc_ok;
   assign retire = resetn & (occ_q != '0) & ret_ok;

   assign bus.addr_ok = accept;
   assign bus.data_ok = retire;
   assign bus.rdata   = (retire && q_is_read_q[rptr_q]) ? q_data_q[rptr_q] : 32'h0;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (accept) wptr_d = wptr_q + PtrW'(1);
      if (retire) rptr_d = rptr_q + PtrW'(1);
      unique case ({accept, retire})
         2'b10:   occ_d = occ_q + OccW'(1);
         2'b01:   occ_d = occ_q - OccW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
      end
   end

   // Memory and queue payload are not reset; reset only discards queue entries.
   always_ff @(posedge clk) begin
      if (accept) begin
         q_is_read_q[wptr_q] <= ~bus.wr;
         q_data_q[wptr_q]    <= bus.wr ? 32'h0 : mem_q[idx];
         if (bus.wr) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.wstrb[b]) mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
         end
      end
   end
endmodule
